// File: rtl/counter_4b_ctrl.sv
// Round-robin sequencer sharing one counter_4b between two requesters.
// Each job is a load cycle followed by LEN count cycles; the final Q is returned with a DONE pulse.
module counter_4b_ctrl #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic [1:0]       REQ,
    input  logic [1:0]       MODE0,
    input  logic [3:0]       VAL0,
    input  logic [LEN_W-1:0] LEN0,
    input  logic [1:0]       MODE1,
    input  logic [3:0]       VAL1,
    input  logic [LEN_W-1:0] LEN1,
    output logic [1:0]       GNT,
    output logic [1:0]       DONE,
    output logic [3:0]       RESULT,
    output logic             BUSY,
    output logic             CNT_ENABLE,
    output logic [1:0]       CNT_MODO,
    output logic [3:0]       CNT_D,
    input  logic [3:0]       CNT_Q
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, FIN} state_t;

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t           state_q, state_d;
    logic [1:0]       job_mode_q, job_mode_d;
    logic [3:0]       job_val_q, job_val_d;
    logic [LEN_W-1:0] job_len_q, job_len_d;
    logic [LEN_W-1:0] cyc_q, cyc_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic             win;

    logic [1:0]       gnt_q, gnt_d;
    logic [1:0]       done_q, done_d;
    logic [3:0]       result_q, result_d;
    logic             busy_q, busy_d;
    logic             en_q, en_d;
    logic [1:0]       modo_q, modo_d;
    logic [3:0]       d_q, d_d;

    // A lone request always wins; on contention the side not granted last wins.
    always_comb begin
        win = 1'b0;
        if (REQ == 2'b10)
            win = 1'b1;
        else if (REQ == 2'b11)
            win = ~last_q;
    end

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (REQ != 2'b00) state_d = LOAD;
            LOAD: state_d = (job_len_q != '0 && job_mode_q != 2'b11) ? RUN : FIN;
            RUN:  if (cyc_q == LEN_ONE) state_d = FIN;
            FIN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Job latch, RUN cycle counter and arbitration pointer
    always_comb begin
        job_mode_d = job_mode_q;
        job_val_d  = job_val_q;
        job_len_d  = job_len_q;
        cyc_d      = cyc_q;
        owner_d    = owner_q;
        last_d     = last_q;
        case (state_q)
            IDLE: begin
                if (REQ != 2'b00) begin
                    job_mode_d = win ? MODE1 : MODE0;
                    job_val_d  = win ? VAL1  : VAL0;
                    job_len_d  = win ? LEN1  : LEN0;
                    owner_d    = win;
                    last_d     = win;
                end
            end
            LOAD:    cyc_d = job_len_q;
            RUN:     cyc_d = cyc_q - LEN_ONE;
            default: ;
        endcase
    end

    // Registered outputs are computed from the state being entered, so the
    // LOAD cycle must take its D value from the job being latched this edge.
    always_comb begin
        gnt_d    = '0;
        done_d   = '0;
        result_d = result_q;
        busy_d   = (state_d != IDLE);
        en_d     = 1'b0;
        modo_d   = 2'b00;
        d_d      = '0;
        if (state_q == IDLE && REQ != 2'b00)
            gnt_d = win ? 2'b10 : 2'b01;
        if (state_q == FIN) begin
            done_d   = owner_q ? 2'b10 : 2'b01;
            result_d = CNT_Q;
        end
        case (state_d)
            LOAD: begin
                en_d   = 1'b1;
                modo_d = 2'b11;
                d_d    = job_val_d;
            end
            RUN: begin
                en_d   = 1'b1;
                modo_d = job_mode_q;
                d_d    = job_val_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            job_mode_q <= '0;
            job_val_q  <= '0;
            job_len_q  <= '0;
            cyc_q      <= '0;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            gnt_q      <= '0;
            done_q     <= '0;
            result_q   <= '0;
            busy_q     <= 1'b0;
            en_q       <= 1'b0;
            modo_q     <= '0;
            d_q        <= '0;
        end else begin
            job_mode_q <= job_mode_d;
            job_val_q  <= job_val_d;
            job_len_q  <= job_len_d;
            cyc_q      <= cyc_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            result_q   <= result_d;
            busy_q     <= busy_d;
            en_q       <= en_d;
            modo_q     <= modo_d;
            d_q        <= d_d;
        end
    end

    assign GNT        = gnt_q;
    assign DONE       = done_q;
    assign RESULT     = result_q;
    assign BUSY       = busy_q;
    assign CNT_ENABLE = en_q;
    assign CNT_MODO   = modo_q;
    assign CNT_D      = d_q;

endmodule

// File: doc/counter_4b_ctrl.md
Name: counter_4b_ctrl

Overview:
Sequencer/arbiter that shares one counter_4b instance between two requesters.
- Each requester submits a job: preload value, counting mode, and number of count cycles.
- The block arbitrates round-robin, latches the winning job, and drives the counter's ENABLE/MODO/D: a load cycle, then N count cycles.
- It then returns the final Q to the requester with a one-cycle done pulse.

Parameters:
LEN_W, 4, width of job length fields (count cycles per job, 0..2^LEN_W-1)

Ports:
clk  input  1  system clock, rising edge
RESET  input  1  asynchronous, active-low reset (0 = reset)
REQ  input  2  job request per requester; held high until matching GNT bit seen
MODE0  input  2  requester 0 count mode (counter MODO encoding: 00 up-by-1, 01 down-by-1, 10 up-by-3, 11 load)
VAL0  input  4  requester 0 preload value
LEN0  input  LEN_W  requester 0 count cycles
MODE1  input  2  requester 1 count mode
VAL1  input  4  requester 1 preload value
LEN1  input  LEN_W  requester 1 count cycles
GNT  output  2  one-cycle grant pulse, one-hot
DONE  output  2  one-cycle completion pulse, one-hot
RESULT  output  4  final counter value of last completed job; held until next DONE
BUSY  output  1  high whenever FSM not in IDLE
CNT_ENABLE  output  1  to counter ENABLE
CNT_MODO  output  2  to counter MODO
CNT_D  output  4  to counter D
CNT_Q  input  4  from counter Q

Behaviour:
- Reset (RESET=0, async):
  - FSM=IDLE.
  - GNT=00, DONE=00, RESULT=0, BUSY=0.
  - CNT_ENABLE=0, CNT_MODO=00, CNT_D=0.
  - Round-robin pointer favours requester 0.
- All outputs are registered; none is combinational from inputs.
- FSM states: IDLE, LOAD, RUN, FIN.
- IDLE:
  - CNT_ENABLE=0.
  - On an edge with REQ!=00: pick winner, latch its MODE/VAL/LEN into job registers, go to LOAD.
  - GNT[winner]=1 for the LOAD cycle only.
- Arbitration:
  - Single request wins.
  - Both requesting: the requester not granted last wins; pointer updates on every grant.
- LOAD (1 cycle): CNT_ENABLE=1, CNT_MODO=11, CNT_D=job VAL; the counter holds VAL after this edge.
  - Next state RUN if job LEN!=0 and job MODE!=11.
  - Otherwise next state FIN; MODE=11 is a pure load.
- RUN:
  - CNT_ENABLE=1, CNT_MODO=job MODE, CNT_D=job VAL.
  - Internal cycle counter loaded with LEN on entry; exactly LEN cycles spent in RUN, then FIN.
- FIN (1 cycle): CNT_ENABLE=0, CNT_MODO=00.
  - On exit edge: RESULT<=CNT_Q, DONE[owner]<=1 for one cycle, FSM->IDLE.
- Job latency from grant: GNT cycle = LOAD; DONE asserts LEN+2 cycles after GNT (LEN=0 or MODE=11: 2 cycles).
- Arithmetic: counter is mod-16; the controller does not saturate or check wrap. RCO is not used.
- REQ changes during LOAD/RUN/FIN are ignored; only the latched job is used.
- A REQ still high in the DONE cycle (IDLE) is a new request; it may be granted on that same edge (back-to-back, no gap cycle).
- Reset mid-job: job abandoned, no DONE issued, counter inputs return to disabled immediately.

Test Plan:
- Reset then REQ=01, MODE0=00, VAL0=14, LEN0=3 -> GNT=01 next cycle; CNT_Q sequence 14,15,0,1; DONE=01 five cycles after GNT; RESULT=1.
- REQ=10, MODE1=01, VAL1=2, LEN1=4 -> RESULT=14 (down wrap), DONE=10 six cycles after GNT.
- REQ=11 held continuously -> grants alternate 01,10,01,10; each DONE matches the preceding GNT owner; RESULT correct per job.
- MODE0=10, VAL0=0, LEN0=2 -> RESULT=6. MODE0=11, VAL0=9, LEN0=7 -> no RUN state, RESULT=9, DONE two cycles after GNT.
- LEN0=0, MODE0=00, VAL0=5 -> RESULT=5, CNT_ENABLE high for exactly one cycle.
- Assert RESET=0 during RUN (async, mid-cycle) -> CNT_ENABLE, BUSY, GNT, DONE drop immediately, no DONE pulse. After release, REQ=11 -> requester 0 granted first.
